// File: rtl/ps2_ascii_decoder_pkg.sv
// Scan-code constants, FSM encoding and the set-2 to ASCII lookup table.
// Latency: none (pure definitions and a combinational helper).
// Backpressure: n/a.
package ps2_ascii_decoder_pkg;

  // Prefix bytes
  localparam logic [7:0] SC_BRK    = 8'hF0;
  localparam logic [7:0] SC_EXT    = 8'hE0;

  // Modifier keys
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_CAPS   = 8'h58;

  // Control keys (Enter is also the keypad Enter code after E0)
  localparam logic [7:0] SC_ENTER  = 8'h5A;
  localparam logic [7:0] SC_BKSP   = 8'h66;
  localparam logic [7:0] SC_TAB    = 8'h0D;
  localparam logic [7:0] SC_ESC    = 8'h76;

  localparam logic [7:0] ASC_CR    = 8'h0D;
  localparam logic [7:0] ASC_BS    = 8'h08;
  localparam logic [7:0] ASC_HT    = 8'h09;
  localparam logic [7:0] ASC_ESC   = 8'h1B;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BRK     = 2'd1,
    ST_EXT     = 2'd2,
    ST_EXT_BRK = 2'd3
  } ps2_state_t;

  // One printable key: lower/upper ASCII and whether Caps Lock affects it
  typedef struct packed {
    logic       vld;
    logic       letter;
    logic [7:0] lo;
    logic [7:0] hi;
  } key_map_t;

  function automatic key_map_t mk_key(input logic letter, input logic [7:0] lo,
                                      input logic [7:0] hi);
    key_map_t k;
    k.vld    = 1'b1;
    k.letter = letter;
    k.lo     = lo;
    k.hi     = hi;
    return k;
  endfunction

  // US set-2 printable keys; everything else comes back with vld=0
  function automatic key_map_t key_lookup(input logic [7:0] code);
    key_map_t k;
    k = '0;
    case (code)
      8'h1C: k = mk_key(1'b1, 8'h61, 8'h41); // a
      8'h32: k = mk_key(1'b1, 8'h62, 8'h42); // b
      8'h21: k = mk_key(1'b1, 8'h63, 8'h43); // c
      8'h23: k = mk_key(1'b1, 8'h64, 8'h44); // d
      8'h24: k = mk_key(1'b1, 8'h65, 8'h45); // e
      8'h2B: k = mk_key(1'b1, 8'h66, 8'h46); // f
      8'h34: k = mk_key(1'b1, 8'h67, 8'h47); // g
      8'h33: k = mk_key(1'b1, 8'h68, 8'h48); // h
      8'h43: k = mk_key(1'b1, 8'h69, 8'h49); // i
      8'h3B: k = mk_key(1'b1, 8'h6A, 8'h4A); // j
      8'h42: k = mk_key(1'b1, 8'h6B, 8'h4B); // k
      8'h4B: k = mk_key(1'b1, 8'h6C, 8'h4C); // l
      8'h3A: k = mk_key(1'b1, 8'h6D, 8'h4D); // m
      8'h31: k = mk_key(1'b1, 8'h6E, 8'h4E); // n
      8'h44: k = mk_key(1'b1, 8'h6F, 8'h4F); // o
      8'h4D: k = mk_key(1'b1, 8'h70, 8'h50); // p
      8'h15: k = mk_key(1'b1, 8'h71, 8'h51); // q
      8'h2D: k = mk_key(1'b1, 8'h72, 8'h52); // r
      8'h1B: k = mk_key(1'b1, 8'h73, 8'h53); // s
      8'h2C: k = mk_key(1'b1, 8'h74, 8'h54); // t
      8'h3C: k = mk_key(1'b1, 8'h75, 8'h55); // u
      8'h2A: k = mk_key(1'b1, 8'h76, 8'h56); // v
      8'h1D: k = mk_key(1'b1, 8'h77, 8'h57); // w
      8'h22: k = mk_key(1'b1, 8'h78, 8'h58); // x
      8'h35: k = mk_key(1'b1, 8'h79, 8'h59); // y
      8'h1A: k = mk_key(1'b1, 8'h7A, 8'h5A); // z
      8'h16: k = mk_key(1'b0, 8'h31, 8'h21); // 1 !
      8'h1E: k = mk_key(1'b0, 8'h32, 8'h40); // 2 @
      8'h26: k = mk_key(1'b0, 8'h33, 8'h23); // 3 #
      8'h25: k = mk_key(1'b0, 8'h34, 8'h24); // 4 $
      8'h2E: k = mk_key(1'b0, 8'h35, 8'h25); // 5 %
      8'h36: k = mk_key(1'b0, 8'h36, 8'h5E); // 6 ^
      8'h3D: k = mk_key(1'b0, 8'h37, 8'h26); // 7 &
      8'h3E: k = mk_key(1'b0, 8'h38, 8'h2A); // 8 *
      8'h46: k = mk_key(1'b0, 8'h39, 8'h28); // 9 (
      8'h45: k = mk_key(1'b0, 8'h30, 8'h29); // 0 )
      8'h0E: k = mk_key(1'b0, 8'h60, 8'h7E); // ` ~
      8'h4E: k = mk_key(1'b0, 8'h2D, 8'h5F); // - _
      8'h55: k = mk_key(1'b0, 8'h3D, 8'h2B); // = +
      8'h54: k = mk_key(1'b0, 8'h5B, 8'h7B); // [ {
      8'h5B: k = mk_key(1'b0, 8'h5D, 8'h7D); // ] }
      8'h5D: k = mk_key(1'b0, 8'h5C, 8'h7C); // \ |
      8'h4C: k = mk_key(1'b0, 8'h3B, 8'h3A); // ; :
      8'h52: k = mk_key(1'b0, 8'h27, 8'h22); // ' "
      8'h41: k = mk_key(1'b0, 8'h2C, 8'h3C); // , <
      8'h49: k = mk_key(1'b0, 8'h2E, 8'h3E); // . >
      8'h4A: k = mk_key(1'b0, 8'h2F, 8'h3F); // / ?
      8'h29: k = mk_key(1'b0, 8'h20, 8'h20); // space
      default: k = '0;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/ps2_ascii_decoder_fifo.sv
// Synchronous first-word-fall-through FIFO with overflow reporting.
// Latency: a write is visible at rd_data one edge later; pop takes effect at the edge.
// Backpressure: writes while full are dropped (overflow_tick) unless a pop happens in the same cycle.
module ascii_fifo #(
  parameter int AW = 3,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          wr,
  input  logic [DW-1:0] wr_data,
  input  logic          rd,
  output logic [DW-1:0] rd_data,
  output logic          full,
  output logic          empty,
  output logic          overflow_tick
);

  localparam int DEPTH = 2 ** AW;

  logic [DW-1:0] mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          do_rd;
  logic          do_wr;

  // Extra pointer MSB separates full from empty when the indices match
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // A pop frees the head slot in the same cycle, so a full FIFO can still accept
  assign do_rd = rd && !empty;
  assign do_wr = wr && (!full || do_rd);

  // Head is forced to zero while empty so the output is defined out of reset
  assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

  // Pointer and overflow state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      overflow_tick <= 1'b0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      overflow_tick <= wr && !do_wr;
    end
  end

  // Storage array, no reset needed since empty gates the output
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/ps2_ascii_decoder.sv
// PS/2 set-2 scan code to ASCII decoder with Shift/Caps tracking feeding an output FIFO.
// Latency: a make byte strobed at edge k is on ascii_out (empty=0) right after edge k.
// Backpressure: none upstream; characters arriving while the FIFO is full are dropped with overflow_tick.
module ps2_ascii_decoder
  import ps2_ascii_decoder_pkg::*;
#(
  parameter int FIFO_AW = 3,
  parameter bit CAPS_EN = 1'b1,
  parameter bit CTRL_EN = 1'b1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rx_done_tick,
  input  logic [7:0] scan_code,
  input  logic       rd,
  output logic [7:0] ascii_out,
  output logic       empty,
  output logic       full,
  output logic       overflow_tick,
  output logic       shift_on,
  output logic       caps_on
);

  ps2_state_t state, state_nxt;
  logic       lshift, lshift_nxt;
  logic       rshift, rshift_nxt;
  logic       caps, caps_nxt;
  logic       caps_held, caps_held_nxt;
  logic       push;
  logic [7:0] push_dat;
  key_map_t   km;
  logic       upper;

  assign km       = key_lookup(scan_code);
  assign shift_on = lshift | rshift;
  assign caps_on  = caps;
  // Caps Lock only affects letters; Shift affects everything printable
  assign upper    = km.letter ? (shift_on ^ caps) : shift_on;

  // State and modifier registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      lshift    <= 1'b0;
      rshift    <= 1'b0;
      caps      <= 1'b0;
      caps_held <= 1'b0;
    end else begin
      state     <= state_nxt;
      lshift    <= lshift_nxt;
      rshift    <= rshift_nxt;
      caps      <= caps_nxt;
      caps_held <= caps_held_nxt;
    end
  end

  // Prefix parsing, modifier updates and character push decision
  always_comb begin
    state_nxt     = state;
    lshift_nxt    = lshift;
    rshift_nxt    = rshift;
    caps_nxt      = caps;
    caps_held_nxt = caps_held;
    push          = 1'b0;
    push_dat      = 8'h00;
    if (rx_done_tick) begin
      case (state)
        ST_IDLE: begin
          if (scan_code == SC_BRK) begin
            state_nxt = ST_BRK;
          end else if (scan_code == SC_EXT) begin
            state_nxt = ST_EXT;
          end else begin
            case (scan_code)
              SC_LSHIFT: lshift_nxt = 1'b1;
              SC_RSHIFT: rshift_nxt = 1'b1;
              SC_CAPS: begin
                // Typematic repeats keep caps_held set, so only the first make toggles
                if (CAPS_EN) begin
                  if (!caps_held) caps_nxt = ~caps;
                  caps_held_nxt = 1'b1;
                end
              end
              SC_ENTER: begin
                push     = CTRL_EN;
                push_dat = ASC_CR;
              end
              SC_BKSP: begin
                push     = CTRL_EN;
                push_dat = ASC_BS;
              end
              SC_TAB: begin
                push     = CTRL_EN;
                push_dat = ASC_HT;
              end
              SC_ESC: begin
                push     = CTRL_EN;
                push_dat = ASC_ESC;
              end
              default: begin
                push     = km.vld;
                push_dat = upper ? km.hi : km.lo;
              end
            endcase
          end
        end
        ST_BRK: begin
          state_nxt = ST_IDLE;
          case (scan_code)
            SC_LSHIFT: lshift_nxt    = 1'b0;
            SC_RSHIFT: rshift_nxt    = 1'b0;
            SC_CAPS:   caps_held_nxt = 1'b0;
            default:   ;
          endcase
        end
        ST_EXT: begin
          if (scan_code == SC_BRK) begin
            state_nxt = ST_EXT_BRK;
          end else if (scan_code == SC_EXT) begin
            state_nxt = ST_EXT;
          end else begin
            state_nxt = ST_IDLE;
            // Keypad Enter is the only extended key that produces a character
            if (scan_code == SC_ENTER) begin
              push     = CTRL_EN;
              push_dat = ASC_CR;
            end
          end
        end
        ST_EXT_BRK: state_nxt = ST_IDLE;
        default:    state_nxt = ST_IDLE;
      endcase
    end
  end

  ascii_fifo #(
    .AW(FIFO_AW),
    .DW(8)
  ) u_fifo (
    .clk          (clk),
    .reset_n      (reset_n),
    .wr           (push),
    .wr_data      (push_dat),
    .rd           (rd),
    .rd_data      (ascii_out),
    .full         (full),
    .empty        (empty),
    .overflow_tick(overflow_tick)
  );

endmodule

// File: tb/tb_ps2_ascii_decoder.sv
module tb_ps2_ascii_decoder;
  import ps2_ascii_decoder_pkg::*;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       rx_done_tick;
  logic [7:0] scan_code;
  logic       rd;
  logic [7:0] ascii_out;
  logic       empty;
  logic       full;
  logic       overflow_tick;
  logic       shift_on;
  logic       caps_on;

  int total = 0;
  int bad   = 0;

  ps2_ascii_decoder #(
    .FIFO_AW(2),
    .CAPS_EN(1'b1),
    .CTRL_EN(1'b1)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .rx_done_tick (rx_done_tick),
    .scan_code    (scan_code),
    .rd           (rd),
    .ascii_out    (ascii_out),
    .empty        (empty),
    .full         (full),
    .overflow_tick(overflow_tick),
    .shift_on     (shift_on),
    .caps_on      (caps_on)
  );

  always #5 clk = ~clk;

  // Drive one byte for a single cycle; returns at a negedge after the sampling edge
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    scan_code    = b;
    rx_done_tick = 1'b1;
    @(negedge clk);
    rx_done_tick = 1'b0;
  endtask

  // Capture the FIFO head and pop it
  task automatic pop(output logic [7:0] d);
    @(negedge clk);
    d  = ascii_out;
    rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL reset_empty got=%b want=1", empty); end
    total++; if (full !== 1'b0) begin bad++; $display("FAIL reset_full got=%b want=0", full); end
    total++; if (overflow_tick !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b want=0", overflow_tick); end
    total++; if (shift_on !== 1'b0 || caps_on !== 1'b0) begin bad++; $display("FAIL reset_mods got=%b%b want=00", shift_on, caps_on); end
    total++; if (ascii_out !== 8'h00) begin bad++; $display("FAIL reset_ascii got=%h want=00", ascii_out); end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_make_break();
    logic [7:0] d;
    send_byte(8'h1C);
    total++; if (empty !== 1'b0 || ascii_out !== 8'h61) begin bad++; $display("FAIL make_a got=%b/%h want=0/61", empty, ascii_out); end
    send_byte(8'hF0);
    send_byte(8'h1C);
    pop(d);
    total++; if (d !== 8'h61) begin bad++; $display("FAIL make_a_pop got=%h want=61", d); end
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL break_no_push empty=%b want=1", empty); end
  endtask

  task automatic test_shift();
    logic [7:0] d;
    send_byte(8'h12);
    total++; if (shift_on !== 1'b1) begin bad++; $display("FAIL shift_set got=%b want=1", shift_on); end
    send_byte(8'h1C);
    send_byte(8'hF0); send_byte(8'h1C);
    send_byte(8'hF0); send_byte(8'h12);
    total++; if (shift_on !== 1'b0) begin bad++; $display("FAIL shift_clr got=%b want=0", shift_on); end
    send_byte(8'h16);
    pop(d);
    total++; if (d !== 8'h41) begin bad++; $display("FAIL shift_A got=%h want=41", d); end
    pop(d);
    total++; if (d !== 8'h31) begin bad++; $display("FAIL shift_1 got=%h want=31", d); end
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL shift_empty got=%b want=1", empty); end
    // Right shift with punctuation, then plain punctuation and space
    send_byte(8'h59); send_byte(8'h4E);
    send_byte(8'hF0); send_byte(8'h59);
    send_byte(8'h4E); send_byte(8'h29);
    pop(d);
    total++; if (d !== 8'h5F) begin bad++; $display("FAIL rshift_underscore got=%h want=5f", d); end
    pop(d);
    total++; if (d !== 8'h2D) begin bad++; $display("FAIL minus got=%h want=2d", d); end
    pop(d);
    total++; if (d !== 8'h20) begin bad++; $display("FAIL space got=%h want=20", d); end
  endtask

  task automatic test_caps();
    logic [7:0] d;
    send_byte(8'h58); send_byte(8'hF0); send_byte(8'h58);
    total++; if (caps_on !== 1'b1) begin bad++; $display("FAIL caps_on got=%b want=1", caps_on); end
    send_byte(8'h1C); send_byte(8'h16);
    send_byte(8'h12); send_byte(8'h1C);
    pop(d);
    total++; if (d !== 8'h41) begin bad++; $display("FAIL caps_A got=%h want=41", d); end
    pop(d);
    total++; if (d !== 8'h31) begin bad++; $display("FAIL caps_digit got=%h want=31", d); end
    pop(d);
    total++; if (d !== 8'h61) begin bad++; $display("FAIL caps_shift_a got=%h want=61", d); end
    send_byte(8'hF0); send_byte(8'h12);
    send_byte(8'h58);
    total++; if (caps_on !== 1'b0) begin bad++; $display("FAIL caps_toggle_off got=%b want=0", caps_on); end
    send_byte(8'h58);
    total++; if (caps_on !== 1'b0) begin bad++; $display("FAIL caps_repeat got=%b want=0", caps_on); end
    send_byte(8'hF0); send_byte(8'h58);
    total++; if (caps_on !== 1'b0) begin bad++; $display("FAIL caps_release got=%b want=0", caps_on); end
  endtask

  task automatic test_ext();
    logic [7:0] d;
    send_byte(8'hE0); send_byte(8'h75);
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL ext_no_push empty=%b want=1", empty); end
    send_byte(8'hE0); send_byte(8'h5A);
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h5A);
    send_byte(8'h66);
    pop(d);
    total++; if (d !== 8'h0D) begin bad++; $display("FAIL ext_enter got=%h want=0d", d); end
    pop(d);
    total++; if (d !== 8'h08) begin bad++; $display("FAIL bksp got=%h want=08", d); end
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL ext_brk_no_push empty=%b want=1", empty); end
  endtask

  task automatic test_overflow();
    logic [7:0] d;
    send_byte(8'h1C); send_byte(8'h32); send_byte(8'h21);
    total++; if (full !== 1'b0) begin bad++; $display("FAIL three_not_full got=%b want=0", full); end
    send_byte(8'h23);
    total++; if (full !== 1'b1 || overflow_tick !== 1'b0) begin bad++; $display("FAIL four_full got=%b/%b want=1/0", full, overflow_tick); end
    send_byte(8'h24);
    total++; if (overflow_tick !== 1'b1) begin bad++; $display("FAIL ovf_pulse got=%b want=1", overflow_tick); end
    @(negedge clk);
    total++; if (overflow_tick !== 1'b0) begin bad++; $display("FAIL ovf_once got=%b want=0", overflow_tick); end
    total++; if (ascii_out !== 8'h61) begin bad++; $display("FAIL ovf_head got=%h want=61", ascii_out); end
    // Write and pop together while full
    scan_code    = 8'h2B;
    rx_done_tick = 1'b1;
    rd           = 1'b1;
    @(negedge clk);
    rx_done_tick = 1'b0;
    rd           = 1'b0;
    total++; if (overflow_tick !== 1'b0 || full !== 1'b1) begin bad++; $display("FAIL rdwr_full got=%b/%b want=0/1", overflow_tick, full); end
    pop(d);
    total++; if (d !== 8'h62) begin bad++; $display("FAIL drain0 got=%h want=62", d); end
    pop(d);
    total++; if (d !== 8'h63) begin bad++; $display("FAIL drain1 got=%h want=63", d); end
    pop(d);
    total++; if (d !== 8'h64) begin bad++; $display("FAIL drain2 got=%h want=64", d); end
    pop(d);
    total++; if (d !== 8'h66) begin bad++; $display("FAIL drain3 got=%h want=66", d); end
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL drained got=%b want=1", empty); end
    // Pop on an empty FIFO must not disturb the pointers
    @(negedge clk); rd = 1'b1;
    @(negedge clk); rd = 1'b0;
    send_byte(8'h1C);
    total++; if (empty !== 1'b0 || ascii_out !== 8'h61) begin bad++; $display("FAIL rd_empty_ignored got=%b/%h want=0/61", empty, ascii_out); end
    pop(d);
  endtask

  task automatic test_reset_mid();
    logic [7:0] d;
    send_byte(8'h1C);
    send_byte(8'h58);
    send_byte(8'hF0);
    total++; if (caps_on !== 1'b1 || empty !== 1'b0) begin bad++; $display("FAIL pre_reset got=%b/%b want=1/0", caps_on, empty); end
    reset_n = 1'b0;
    #1;
    total++; if (empty !== 1'b1 || caps_on !== 1'b0) begin bad++; $display("FAIL mid_reset got=%b/%b want=1/0", empty, caps_on); end
    @(negedge clk);
    reset_n = 1'b1;
    send_byte(8'h1C);
    pop(d);
    total++; if (d !== 8'h61) begin bad++; $display("FAIL prefix_discard got=%h want=61", d); end
  endtask

  initial begin
    reset_n      = 1'b0;
    rx_done_tick = 1'b0;
    scan_code    = 8'h00;
    rd           = 1'b0;
    test_reset();
    test_make_break();
    test_shift();
    test_caps();
    test_ext();
    test_overflow();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
